// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch front
//               end: datapath width, default reset PC, queue entry layout,
//               derived control state and the counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'd0;

    // One queued instruction together with the word address it came from.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // RUN: responses are delivered. FLUSH: responses belonging to requests
    // issued before a redirect are still in flight and must be discarded.
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_e;

    // Width of a counter able to hold the values 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Synchronous FIFO holding fetched instructions. Head data is
//               read straight from the storage array, so an entry written in
//               cycle N is visible at head in cycle N+1. flush empties the
//               queue and voids any same-cycle push or pop.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               flush         - discard all entries
//               push/push_data- write one entry
//               pop           - remove the head entry
//               full/empty    - occupancy flags
//               count         - number of valid entries (0..DEPTH)
//               head          - oldest entry (valid while !empty)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2 * XLEN
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic                        full,
    output logic                        empty,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic [WIDTH-1:0]            head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;

    logic w_do_pop;
    logic w_do_push;

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

    // A push into a full queue is still legal when the head leaves in the
    // same cycle.
    assign w_do_pop  = pop && !empty && !flush;
    assign w_do_push = push && (!full || w_do_pop) && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch front end. Issues word-addressed requests
//               to an in-order, variable-latency instruction memory, queues
//               the returned words with their PCs and hands them to the
//               datapath one per handshake. A redirect flushes the queue and
//               discards responses still in flight.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               redirect_valid/_pc       - taken branch, new word address
//               mem_req_valid/_ready/_addr - fetch request channel
//               mem_rsp_valid/_data      - fetch response (no backpressure)
//               instr_valid/_ready       - instruction handshake to datapath
//               instr, instr_pc          - head instruction and its address
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
);

    localparam int CW = cnt_width(DEPTH);

    // ------------------------------------------------------------------
    // Registered control state
    // ------------------------------------------------------------------
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;

    logic [XLEN-1:0] w_fetch_pc_nxt;
    logic [XLEN-1:0] w_rsp_pc_nxt;
    logic [CW-1:0]   w_outstanding_nxt;
    logic [CW-1:0]   w_drop_cnt_nxt;

    // ------------------------------------------------------------------
    // Queue interface
    // ------------------------------------------------------------------
    logic            w_q_push;
    logic            w_q_pop;
    logic            w_q_full;
    logic            w_q_empty;
    logic [CW-1:0]   w_q_count;
    fetch_entry_t    w_q_head;
    fetch_entry_t    w_q_push_data;

    fetch_state_e    w_state;
    logic            w_req_fire;
    logic [CW-1:0]   w_out_after_rsp;
    logic [CW:0]     w_credit_used;

    // Control state is a pure function of the pending-drop counter.
    assign w_state = (r_drop_cnt != '0) ? ST_FLUSH : ST_RUN;

    // Every outstanding request owns a queue slot, so responses can always
    // be written without a ready signal.
    assign w_credit_used = {1'b0, w_q_count} + {1'b0, r_outstanding};

    assign mem_req_valid = !rst
                        && !redirect_valid
                        && (r_outstanding < CW'(MAX_OUT))
                        && (w_credit_used < (CW+1)'(DEPTH))
                        && !w_q_full;
    assign mem_req_addr  = r_fetch_pc;
    assign w_req_fire    = mem_req_valid && mem_req_ready;

    assign w_out_after_rsp = r_outstanding - CW'(mem_rsp_valid);

    assign w_q_push      = mem_rsp_valid && !redirect_valid && (w_state == ST_RUN);
    assign w_q_pop       = instr_valid && instr_ready && !redirect_valid;
    assign w_q_push_data = '{instr: mem_rsp_data, pc: r_rsp_pc};

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (w_q_push),
        .push_data (w_q_push_data),
        .pop       (w_q_pop),
        .full      (w_q_full),
        .empty     (w_q_empty),
        .count     (w_q_count),
        .head      (w_q_head)
    );

    assign instr_valid = !w_q_empty;
    assign instr       = w_q_empty ? '0 : w_q_head.instr;
    assign instr_pc    = w_q_empty ? '0 : w_q_head.pc;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_fetch_pc_nxt    = r_fetch_pc;
        w_rsp_pc_nxt      = r_rsp_pc;
        w_drop_cnt_nxt    = r_drop_cnt;
        w_outstanding_nxt = w_out_after_rsp + CW'(w_req_fire);

        if (redirect_valid) begin
            w_fetch_pc_nxt = redirect_pc;
            w_rsp_pc_nxt   = redirect_pc;
            // Everything still in flight after this cycle belongs to the old
            // path; this count already includes any earlier pending drops.
            w_drop_cnt_nxt = w_out_after_rsp;
        end else begin
            if (w_req_fire) begin
                w_fetch_pc_nxt = r_fetch_pc + XLEN'(1);
            end
            if (mem_rsp_valid) begin
                if (w_state == ST_FLUSH) begin
                    w_drop_cnt_nxt = r_drop_cnt - CW'(1);
                end else begin
                    w_rsp_pc_nxt = r_rsp_pc + XLEN'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_rsp_pc      <= w_rsp_pc_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_drop_cnt    <= w_drop_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. An in-order memory with
//               configurable latency answers requests; a queue-level model
//               predicts issue permission, queue occupancy and the delivered
//               PC/instruction stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'd0;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH),
        .MAX_OUT  (MAX_OUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;
    int cyc;

    // Memory configuration
    int lat_min, lat_max, rdy_pct, rsp_pct;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];

    // Reference model: counts of queued, in-flight and stale words, and the
    // next expected request / delivered addresses.
    int          m_q, m_out, m_stale;
    logic [31:0] exp_req_addr, exp_del_pc;
    int          delivered;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_mem();
        mem_req_ready = ($urandom_range(99) < rdy_pct);
        if (!rst && pend.size() != 0 && pend[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(pend[0].addr);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 32'hDEADBEEF;
        end
    endtask

    // Called #1 after the falling edge with inputs stable: check, update the
    // model with this cycle's handshakes, advance to the next falling edge.
    task automatic cycle_end();
        logic exp_rv;
        logic pop, fire, rsp;
        exp_rv = !rst && !redirect_valid && (m_out < MAX_OUT) && ((m_q + m_out) < DEPTH);
        check("mem_req_valid", mem_req_valid, exp_rv);
        if (!rst) check("instr_valid", instr_valid, (m_q != 0));
        if (!rst && mem_req_valid) check("mem_req_addr", mem_req_addr, exp_req_addr);
        pop = !rst && !redirect_valid && (m_q != 0) && instr_ready;
        if (pop) begin
            check("instr_pc", instr_pc, exp_del_pc);
            check("instr", instr, mem_word(exp_del_pc));
        end
        fire = mem_req_valid && mem_req_ready;
        rsp  = mem_rsp_valid;
        if (rst) begin
            pend.delete();
            m_q = 0; m_out = 0; m_stale = 0;
            exp_req_addr = RESET_PC;
            exp_del_pc   = RESET_PC;
        end else begin
            if (rsp && pend.size() != 0) begin
                void'(pend.pop_front());
                m_out--;
            end
            if (redirect_valid) begin
                m_stale      = m_out;
                m_q          = 0;
                exp_req_addr = redirect_pc;
                exp_del_pc   = redirect_pc;
            end else begin
                if (rsp) begin
                    if (m_stale > 0) m_stale--;
                    else m_q++;
                end
                if (pop) begin
                    m_q--;
                    exp_del_pc = exp_del_pc + 32'd1;
                    delivered++;
                end
                if (fire) exp_req_addr = exp_req_addr + 32'd1;
            end
            if (fire) begin
                pend.push_back(pend_t'{mem_req_addr, cyc + int'($urandom_range(lat_max, lat_min))});
                m_out++;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic tick();
        drive_mem();
        #1;
        cycle_end();
    endtask

    task automatic do_reset(input int lat, input bit ir);
        lat_min = lat; lat_max = lat; rdy_pct = 100; rsp_pct = 100;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = ir;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_delivery(input int budget, input string name, input logic [31:0] exp_pc);
        bit          ok;
        logic [31:0] pc;
        ok = 1'b0;
        pc = '0;
        for (int i = 0; i < budget && !ok; i++) begin
            drive_mem();
            #1;
            if (instr_valid && instr_ready) begin
                pc = instr_pc;
                ok = 1'b1;
            end
            cycle_end();
        end
        if (ok) check(name, pc, exp_pc);
        else begin
            checks++; failures++;
            $display("FAIL %s: no delivery within %0d cycles, expected pc %h", name, budget, exp_pc);
        end
    endtask

    // Wait (bounded) for two requests in flight with something queued, then
    // redirect in that same cycle.
    task automatic redirect_when_loaded(input logic [31:0] target, input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            drive_mem();
            if (m_out == 2 && m_q >= 1) begin
                redirect_valid = 1'b1;
                redirect_pc    = target;
                done           = 1'b1;
            end
            #1;
            cycle_end();
            redirect_valid = 1'b0;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL %s: loaded state not reached, got 0 expected 1", name);
        end
    endtask

    typedef struct {
        bit          ir;
        bit          rv;
        logic [31:0] ra;
        bit          iv;
        logic [31:0] ipc;
    } vec_t;
    vec_t tab[25];

    typedef struct {
        int lmin, lmax, rdy, rsp, ir, redir;
    } cfg_t;
    cfg_t cfgs[4];

    initial begin
        checks = 0; failures = 0; cyc = 0; delivered = 0;
        m_q = 0; m_out = 0; m_stale = 0;
        exp_req_addr = RESET_PC; exp_del_pc = RESET_PC;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        lat_min = 1; lat_max = 1; rdy_pct = 100; rsp_pct = 100;

        // Back-pressure table: zero-wait-state memory, datapath stalled for
        // 20 cycles then draining.
        tab[0] = '{0, 1, 32'd0, 0, 32'd0};
        tab[1] = '{0, 1, 32'd1, 0, 32'd0};
        tab[2] = '{0, 1, 32'd2, 1, 32'd0};
        tab[3] = '{0, 1, 32'd3, 1, 32'd0};
        for (int i = 4; i < 20; i++) tab[i] = '{0, 0, 32'd0, 1, 32'd0};
        tab[20] = '{1, 0, 32'd0, 1, 32'd0};
        tab[21] = '{1, 1, 32'd4, 1, 32'd1};
        tab[22] = '{1, 1, 32'd5, 1, 32'd2};
        tab[23] = '{1, 1, 32'd6, 1, 32'd3};
        tab[24] = '{1, 1, 32'd7, 1, 32'd4};

        cfgs[0] = '{1, 1, 100, 100, 80, 3};
        cfgs[1] = '{1, 4,  60,  70, 50, 4};
        cfgs[2] = '{2, 5,  40,  50, 30, 2};
        cfgs[3] = '{1, 3,  90,  90, 95, 8};

        @(negedge clk);

        // ---- Full queue / back-pressure (table driven) ----
        do_reset(1, 1'b0);
        for (int i = 0; i < 25; i++) begin
            instr_ready = tab[i].ir;
            drive_mem();
            #1;
            if (i == 0) begin
                check("reset_instr", instr, 32'd0);
                check("reset_instr_pc", instr_pc, 32'd0);
            end
            check("tab_req_valid", mem_req_valid, tab[i].rv);
            if (tab[i].rv) check("tab_req_addr", mem_req_addr, tab[i].ra);
            check("tab_instr_valid", instr_valid, tab[i].iv);
            if (tab[i].iv) check("tab_instr_pc", instr_pc, tab[i].ipc);
            cycle_end();
        end

        // ---- Steady-state throughput with 1-cycle memory ----
        begin
            int d0;
            do_reset(1, 1'b1);
            repeat (10) tick();
            d0 = delivered;
            repeat (20) tick();
            check("throughput", delivered - d0, 20);
        end

        // ---- 3-cycle latency, 50 fetches, outstanding bound ----
        begin
            int d0;
            do_reset(3, 1'b1);
            d0 = delivered;
            for (int i = 0; i < 600 && (delivered - d0) < 50; i++) begin
                tick();
                if (m_out > MAX_OUT) check("outstanding_bound", m_out, MAX_OUT);
            end
            check("lat3_fetch_count", (delivered - d0) >= 50, 1);
        end

        // ---- Redirect with requests in flight and words queued ----
        do_reset(3, 1'b0);
        redirect_when_loaded(32'h40, "redir_load");
        drive_mem(); #1;
        check("redir_queue_empty", instr_valid, 1'b0);
        cycle_end();
        instr_ready = 1'b1;
        wait_delivery(40, "redir_first_pc", 32'h40);
        wait_delivery(40, "redir_second_pc", 32'h41);

        // ---- Redirect coinciding with a response and a dequeue ----
        begin
            bit done;
            do_reset(2, 1'b1);
            done = 1'b0;
            for (int i = 0; i < 40 && !done; i++) begin
                drive_mem();
                if (mem_rsp_valid && m_q != 0) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = 32'h100;
                    done           = 1'b1;
                end
                #1;
                cycle_end();
                redirect_valid = 1'b0;
            end
            check("coincide_reached", done, 1'b1);
            drive_mem(); #1;
            check("coincide_queue_empty", instr_valid, 1'b0);
            cycle_end();
            wait_delivery(40, "coincide_first_pc", 32'h100);
        end

        // ---- Reset while flushing ----
        do_reset(3, 1'b0);
        redirect_when_loaded(32'h80, "flushrst_load");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive_mem(); #1;
        check("flushrst_instr_valid", instr_valid, 1'b0);
        check("flushrst_req_valid", mem_req_valid, 1'b1);
        check("flushrst_req_addr", mem_req_addr, RESET_PC);
        cycle_end();
        instr_ready = 1'b1;
        wait_delivery(40, "flushrst_first_pc", RESET_PC);

        // ---- PC wrap ----
        do_reset(1, 1'b1);
        drive_mem();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFFFFFE;
        #1;
        cycle_end();
        redirect_valid = 1'b0;
        wait_delivery(40, "wrap_pc0", 32'hFFFFFFFE);
        wait_delivery(40, "wrap_pc1", 32'hFFFFFFFF);
        wait_delivery(40, "wrap_pc2", 32'h00000000);

        // ---- Randomised traffic against the model ----
        for (int c = 0; c < 4; c++) begin
            do_reset(1, 1'b0);
            lat_min = cfgs[c].lmin; lat_max = cfgs[c].lmax;
            rdy_pct = cfgs[c].rdy;  rsp_pct = cfgs[c].rsp;
            for (int i = 0; i < 700; i++) begin
                rst            = ($urandom_range(199) == 0);
                redirect_valid = !rst && ($urandom_range(99) < cfgs[c].redir);
                redirect_pc    = $urandom_range(1) ? (32'hFFFFFFF0 + 32'($urandom_range(15))) : $urandom;
                instr_ready    = ($urandom_range(99) < cfgs[c].ir);
                tick();
            end
            rst = 1'b0; redirect_valid = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
